mc_ctrl: RTL and testbench

- Multi-cycle control unit for the MIPS datapath (PC, IM, RF, EXT, ALU, DM); replaces the single-cycle combinational decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives PC/IR/RF/DM write enables and the datapath mux selects.
- Inserts DM wait states via a ready handshake.

---
 rtl/mc_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: 2-5 cycles per instruction plus DM wait cycles; outputs track the state register.
// Backpressure: MRD/MWR hold (dm_req high) until dm_rdy; dm_rdy ignored elsewhere.
//
// Ports:
//   clk, rst (async, active-low)        clock / reset
//   op, funct                           IR[31:26] / IR[5:0], stable from DCD onward
//   zero                                ALU zero flag, gates PCWr in BR
//   dm_rdy / dm_req                     DM access handshake
//   PCWr IRWr RFWr DMWr                 write enables
//   NPCOp EXTOp ALUOp BSel RegDst Mem2R datapath selects
//   illegal                             one-cycle pulse in DCD on an unsupported instruction
//   state                               current state (debug)
// Optional: MC_CTRL_PERF_EN adds instr_cnt, a wrapping count of retired legal instructions.
module mc_ctrl #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            dm_rdy,
  output logic            PCWr,
  output logic            IRWr,
  output logic            RFWr,
  output logic            DMWr,
  output logic            dm_req,
  output logic [1:0]      NPCOp,
  output logic [1:0]      EXTOp,
  output logic [1:0]      ALUOp,
  output logic            BSel,
  output logic            RegDst,
  output logic            Mem2R,
  output logic            illegal,
`ifdef MC_CTRL_PERF_EN
  output logic [31:0]     instr_cnt,
`endif
  output logic [ST_W-1:0] state
);

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_W'(0),
    S_FETCH = ST_W'(1),
    S_DCD   = ST_W'(2),
    S_EXE_R = ST_W'(3),
    S_EXE_I = ST_W'(4),
    S_WB    = ST_W'(5),
    S_MA    = ST_W'(6),
    S_MRD   = ST_W'(7),
    S_MWB   = ST_W'(8),
    S_MWR   = ST_W'(9),
    S_BR    = ST_W'(10),
    S_JMP   = ST_W'(11)
  } st_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  st_t        r_st;
  st_t        w_nxt;
  logic       r_pcwr;
  logic       w_is_rtype;
  logic       w_is_subu;
  logic       w_is_ori;
  logic       w_is_lw;
  logic       w_is_mem;
  logic       w_is_beq;
  logic       w_is_j;
  logic       w_legal;

  // Instruction classification straight from the IR fields.
  assign w_is_rtype = (op == OP_RTYPE) && ((funct == FN_ADDU) || (funct == FN_SUBU));
  assign w_is_subu  = (op == OP_RTYPE) && (funct == FN_SUBU);
  assign w_is_ori   = (op == OP_ORI);
  assign w_is_lw    = (op == OP_LW);
  assign w_is_mem   = (op == OP_LW) || (op == OP_SW);
  assign w_is_beq   = (op == OP_BEQ);
  assign w_is_j     = (op == OP_J);
  assign w_legal    = w_is_rtype || w_is_ori || w_is_mem || w_is_beq || w_is_j;

  always_comb begin
    w_nxt = S_IDLE;
    case (r_st)
      S_IDLE:  w_nxt = S_FETCH;
      S_FETCH: w_nxt = S_DCD;
      S_DCD: begin
        if (w_is_rtype)    w_nxt = S_EXE_R;
        else if (w_is_ori) w_nxt = S_EXE_I;
        else if (w_is_mem) w_nxt = S_MA;
        else if (w_is_beq) w_nxt = S_BR;
        else if (w_is_j)   w_nxt = S_JMP;
        else               w_nxt = S_FETCH;
      end
      S_EXE_R: w_nxt = S_WB;
      S_EXE_I: w_nxt = S_WB;
      S_WB:    w_nxt = S_FETCH;
      S_MA:    w_nxt = w_is_lw ? S_MRD : S_MWR;
      S_MRD:   w_nxt = dm_rdy ? S_MWB : S_MRD;
      S_MWB:   w_nxt = S_FETCH;
      S_MWR:   w_nxt = dm_rdy ? S_FETCH : S_MWR;
      S_BR:    w_nxt = S_FETCH;
      S_JMP:   w_nxt = S_FETCH;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State and outputs are registered together: the outputs loaded at each edge
  // are the decode of the state being entered, so they always match r_st.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st   <= S_IDLE;
      r_pcwr <= 1'b0;
      IRWr   <= 1'b0;
      RFWr   <= 1'b0;
      DMWr   <= 1'b0;
      dm_req <= 1'b0;
      NPCOp  <= 2'b00;
      EXTOp  <= 2'b00;
      ALUOp  <= 2'b00;
      BSel   <= 1'b0;
      RegDst <= 1'b0;
      Mem2R  <= 1'b0;
    end else begin
      r_st   <= w_nxt;
      r_pcwr <= 1'b0;
      IRWr   <= 1'b0;
      RFWr   <= 1'b0;
      DMWr   <= 1'b0;
      dm_req <= 1'b0;
      NPCOp  <= 2'b00;
      EXTOp  <= 2'b00;
      ALUOp  <= 2'b00;
      BSel   <= 1'b0;
      RegDst <= 1'b0;
      Mem2R  <= 1'b0;
      case (w_nxt)
        S_FETCH: begin
          IRWr   <= 1'b1;
          r_pcwr <= 1'b1;
        end
        S_DCD:   EXTOp <= 2'b01;
        S_EXE_R: ALUOp <= w_is_subu ? 2'b01 : 2'b00;
        S_EXE_I: begin
          BSel  <= 1'b1;
          ALUOp <= 2'b10;
        end
        S_WB: begin
          // ALU controls repeat the EXE decode so the result stays valid at write.
          RFWr <= 1'b1;
          if (op == OP_RTYPE) begin
            RegDst <= 1'b1;
            ALUOp  <= w_is_subu ? 2'b01 : 2'b00;
          end else begin
            BSel  <= 1'b1;
            ALUOp <= 2'b10;
          end
        end
        S_MA, S_MRD: begin
          BSel   <= 1'b1;
          EXTOp  <= 2'b01;
          dm_req <= (w_nxt == S_MRD);
        end
        S_MWB: begin
          RFWr  <= 1'b1;
          Mem2R <= 1'b1;
        end
        S_MWR: begin
          // Address controls held and DMWr repeated on every wait cycle.
          BSel   <= 1'b1;
          EXTOp  <= 2'b01;
          dm_req <= 1'b1;
          DMWr   <= 1'b1;
        end
        S_BR: begin
          ALUOp <= 2'b01;
          NPCOp <= 2'b01;
          EXTOp <= 2'b01;
        end
        S_JMP: begin
          r_pcwr <= 1'b1;
          NPCOp  <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  // BR is the one Mealy-style exception: the PC update depends on this cycle's zero.
  assign PCWr    = r_pcwr || ((r_st == S_BR) && zero);
  // IR is only loaded at the FETCH->DCD edge, so legality is judged live in DCD.
  assign illegal = (r_st == S_DCD) && !w_legal;
  assign state   = r_st;

`ifdef MC_CTRL_PERF_EN
  logic w_retire;
  assign w_retire = (w_nxt == S_FETCH) &&
                    ((r_st == S_WB) || (r_st == S_MWB) || (r_st == S_MWR) ||
                     (r_st == S_BR) || (r_st == S_JMP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          instr_cnt <= 32'd0;
    else if (w_retire) instr_cnt <= instr_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed plan steps followed by a random instruction mix.
// Per-cycle state and control vector compared against an instruction-level reference model.
// DM wait cycles, zero flag and idle dm_rdy noise are randomized.
module tb_mc_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       dm_rdy;
  logic       PCWr, IRWr, RFWr, DMWr, dm_req, BSel, RegDst, Mem2R, illegal;
  logic [1:0] NPCOp, EXTOp, ALUOp;
  logic [3:0] state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_cnt;
  int unsigned m_cnt;
`endif

  int n_vec;
  int n_err;

  // Instruction classes of the reference model.
  localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LW = 3, C_SW = 4,
                 C_BEQ = 5, C_J = 6, C_ILL = 7;

  mc_ctrl #(.ST_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .dm_rdy(dm_rdy),
    .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr), .dm_req(dm_req),
    .NPCOp(NPCOp), .EXTOp(EXTOp), .ALUOp(ALUOp), .BSel(BSel), .RegDst(RegDst),
    .Mem2R(Mem2R), .illegal(illegal),
`ifdef MC_CTRL_PERF_EN
    .instr_cnt(instr_cnt),
`endif
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control vector, field order matches vec() below.
  function automatic logic [14:0] obs_vec();
    return {PCWr, IRWr, RFWr, DMWr, dm_req, NPCOp, EXTOp, ALUOp, BSel, RegDst, Mem2R, illegal};
  endfunction

  function automatic logic [14:0] vec(input logic pc, input logic ir, input logic rf,
                                      input logic dw, input logic rq, input logic [1:0] npc,
                                      input logic [1:0] ext, input logic [1:0] alu,
                                      input logic bs, input logic rd, input logic m2r,
                                      input logic ill);
    return {pc, ir, rf, dw, rq, npc, ext, alu, bs, rd, m2r, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, {28'd0, state}, 32'd0);
    chk({tag, "_outs"}, {17'd0, obs_vec()}, 32'd0);
  endtask

  // 32-bit encoding for a class; unused fields randomized.
  function automatic logic [31:0] encode(input int cls);
    logic [31:0] w;
    logic [5:0]  o;
    logic [5:0]  f;
    w = $urandom;
    case (cls)
      C_ADDU: begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
      C_SUBU: begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
      C_ORI:  w[31:26] = 6'h0D;
      C_LW:   w[31:26] = 6'h23;
      C_SW:   w[31:26] = 6'h2B;
      C_BEQ:  w[31:26] = 6'h04;
      C_J:    w[31:26] = 6'h02;
      default: begin
        for (int t = 0; t < 100; t++) begin
          o = 6'($urandom);
          f = 6'($urandom);
          if (!((o == 6'h00 && (f == 6'h21 || f == 6'h23)) || o == 6'h0D || o == 6'h23 ||
                o == 6'h2B || o == 6'h04 || o == 6'h02)) break;
        end
        if ((o == 6'h00 && (f == 6'h21 || f == 6'h23)) || o == 6'h0D || o == 6'h23 ||
            o == 6'h2B || o == 6'h04 || o == 6'h02) o = 6'h3F;
        w[31:26] = o;
        w[5:0]   = f;
      end
    endcase
    return w;
  endfunction

  // Run one instruction starting in its FETCH cycle. The expected state trace and
  // control values per cycle come from the instruction class and the wait count.
  // abort_idx >= 0 pulls reset low during that cycle.
  task automatic run_instr(input int cls, input logic [31:0] instr, input int waits,
                           input logic zbit, input int abort_idx);
    int          seq[$];
    int          st;
    int          k;
    logic [14:0] e;
    seq = {1, 2};
    case (cls)
      C_ADDU, C_SUBU: seq = {seq, 3, 5};
      C_ORI:          seq = {seq, 4, 5};
      C_LW: begin seq.push_back(6); for (int i = 0; i <= waits; i++) seq.push_back(7); seq.push_back(8); end
      C_SW: begin seq.push_back(6); for (int i = 0; i <= waits; i++) seq.push_back(9); end
      C_BEQ:          seq.push_back(10);
      C_J:            seq.push_back(11);
      default: ;
    endcase
    k = 0;
    for (int c = 0; c < seq.size(); c++) begin
      @(negedge clk);
      st     = seq[c];
      op     = instr[31:26];
      funct  = instr[5:0];
      zero   = (st == 10) ? zbit : 1'($urandom);
      if (st == 7 || st == 9) begin
        dm_rdy = (k == waits);
        k++;
      end else begin
        dm_rdy = 1'($urandom);
      end
      if (c == abort_idx) begin
        rst = 1'b0;
        #1;
        chk_all_zero("abort_rst_low");
`ifdef MC_CTRL_PERF_EN
        m_cnt = 0;
        chk("abort_cnt", instr_cnt, 32'(m_cnt));
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("abort_idle");
        return;
      end
      #1;
      case (st)
        1:  e = vec(1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        2:  e = vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, cls == C_ILL);
        3:  e = vec(0, 0, 0, 0, 0, 2'b00, 2'b00, (cls == C_SUBU) ? 2'b01 : 2'b00, 0, 0, 0, 0);
        4:  e = vec(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0, 0);
        5:  e = (cls == C_ORI) ? vec(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0, 0)
                               : vec(0, 0, 1, 0, 0, 2'b00, 2'b00,
                                     (cls == C_SUBU) ? 2'b01 : 2'b00, 0, 1, 0, 0);
        6:  e = vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0);
        7:  e = vec(0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0);
        8:  e = vec(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
        9:  e = vec(0, 0, 0, 1, 1, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0);
        10: e = vec(zbit, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 0, 0, 0, 0);
        default: e = vec(1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
      endcase
      chk($sformatf("state_c%0d_i%h", c, instr), {28'd0, state}, 32'(st));
      chk($sformatf("outs_c%0d_i%h", c, instr), {17'd0, obs_vec()}, {17'd0, e});
`ifdef MC_CTRL_PERF_EN
      if (c == 0) chk("instr_cnt", instr_cnt, 32'(m_cnt));
`endif
    end
`ifdef MC_CTRL_PERF_EN
    if (cls != C_ILL) m_cnt++;
`endif
  endtask

  initial begin
    int cls;
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b0;
    op     = 6'h00;
    funct  = 6'h00;
    zero   = 1'b0;
    dm_rdy = 1'b0;
`ifdef MC_CTRL_PERF_EN
    m_cnt  = 0;
`endif
    // Reset held: state and all controls zero.
    @(negedge clk);
    zero = 1'b1; dm_rdy = 1'b1;
    #1;
    chk_all_zero("reset");
`ifdef MC_CTRL_PERF_EN
    chk("reset_cnt", instr_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("idle_after_reset");

    // Directed plan.
    run_instr(C_ADDU, 32'h00221821, 0, 1'b0, 2);   // reset pulse in EXE_R
    run_instr(C_ADDU, 32'h00221821, 0, 1'b0, -1);
    run_instr(C_ORI,  32'h34010005, 0, 1'b0, -1);
    run_instr(C_LW,   32'h8C040008, 3, 1'b0, -1);
    run_instr(C_SW,   32'hAC04000C, 0, 1'b0, -1);
    run_instr(C_BEQ,  32'h10220003, 0, 1'b1, -1);
    run_instr(C_BEQ,  32'h10220003, 0, 1'b0, -1);
    run_instr(C_J,    32'h08000010, 0, 1'b0, -1);
    run_instr(C_ILL,  32'hFC000000, 0, 1'b0, -1);
    run_instr(C_SUBU, 32'h00221823, 0, 1'b0, -1);
    run_instr(C_SW,   32'hAC04000C, 2, 1'b0, -1);
    run_instr(C_LW,   32'h8C040008, 0, 1'b0, -1);

    // Random instruction mix.
    for (int n = 0; n < 80; n++) begin
      cls = int'($urandom_range(7, 0));
      run_instr(cls, encode(cls), int'($urandom_range(3, 0)), 1'($urandom), -1);
    end

    // Closing FETCH check also covers the last retirement count.
    run_instr(C_J, 32'h08000010, 0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
